stream_framer: RTL and testbench



---
 rtl/stream_framer_pkg.sv | 23 ++
 rtl/axis_out_reg.sv | 49 ++++
 rtl/stream_framer.sv | 179 +++++++++++++++++
 tb/tb_stream_framer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_framer_pkg.sv
// ---------------------------------------------------------------------------
// stream_framer_pkg
// Shared types and helpers for the stream_framer block.
//   state_t  : framing state (SEEK = hunting for channel 0, LOCK = aligned)
//   sat_inc  : saturating increment of a counter held in the low 'width'
//              bits of a 32-bit value (width must be 1..32)
// ---------------------------------------------------------------------------
package stream_framer_pkg;

    typedef enum logic {
        SEEK = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Increment 'value' but stop at the all-ones value of a 'width'-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// ---------------------------------------------------------------------------
// axis_out_reg
// Single-entry AXI-Stream register slice. The caller decides when to load
// (it must only load while s_ready is high); the slice holds the word until
// the consumer takes it.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : capture s_data this cycle
//   s_data    : word to capture
//   s_ready   : slice can accept a word this cycle (empty or draining)
//   m_data    : registered word, stable while m_valid && !m_ready
//   m_valid   : registered valid
//   m_ready   : downstream ready
// ---------------------------------------------------------------------------
module axis_out_reg
    import stream_framer_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] s_data,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
);

    logic [W-1:0] data_reg;
    logic         valid_reg;

    // The slot frees up in the same cycle it is drained, giving 1 beat/cycle.
    assign s_ready = !valid_reg || m_ready;
    assign m_data  = data_reg;
    assign m_valid = valid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (load) begin
            data_reg  <= s_data;
            valid_reg <= 1'b1;
        end else if (m_ready) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_framer.sv
// ---------------------------------------------------------------------------
// stream_framer
// Re-frames an interleaved multichannel sample stream (tid = channel 0..NCH-1
// in order) into frames with tlast on channel NCH-1. Out-of-order beats are
// dropped and the framer re-locks on the next channel-0 sample, so downstream
// never sees a misaligned frame.
//   clk, rst          : clock, asynchronous active-high reset
//   s_axis_*          : sample input (tdata, tid, tvalid, tready)
//   m_axis_*          : framed output (tdata, tid, tlast, tvalid, tready)
//   synced            : high while the framer is locked to the channel order
//   err_count         : saturating count of channel-order faults (ERRW <= 32)
// Optional (macro STREAM_FRAMER_STATS_EN):
//   clr_stats         : synchronous clear of frame_count and err_count
//   frame_count       : wrapping count of output beats handshaken with tlast
// ---------------------------------------------------------------------------
module stream_framer
    import stream_framer_pkg::*;
#(
    parameter int DW   = 24,
    parameter int TIDW = 8,
    parameter int NCH  = 2,
    parameter int ERRW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   s_axis_tdata,
    input  logic [TIDW-1:0] s_axis_tid,
    input  logic            s_axis_tvalid,
    output logic            s_axis_tready,
    output logic [DW-1:0]   m_axis_tdata,
    output logic [TIDW-1:0] m_axis_tid,
    output logic            m_axis_tlast,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready,
    output logic            synced,
    output logic [ERRW-1:0] err_count
`ifdef STREAM_FRAMER_STATS_EN
    ,
    input  logic            clr_stats,
    output logic [31:0]     frame_count
`endif
);

    localparam int EW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [EW-1:0] LAST_CH    = EW'(NCH - 1);
    // Channel expected after a channel-0 beat: 1, or 0 again for single-channel frames.
    localparam logic [EW-1:0] FIRST_NEXT = (NCH == 1) ? '0 : EW'(1);
    localparam logic          NCH_IS_ONE = (NCH == 1);

    state_t          state_reg, state_next;
    logic [EW-1:0]   exp_ch_reg, exp_ch_next;
    logic [ERRW-1:0] err_reg, err_next;
    logic            synced_reg;

    logic            accept;
    logic            fwd;
    logic            tlast_in;
    logic            err_inc;
    logic            tid_is_zero;
    logic            tid_match;
    logic [EW-1:0]   exp_ch_wrap;

    assign accept      = s_axis_tvalid && s_axis_tready;
    assign tid_is_zero = (s_axis_tid == '0);
    // exp_ch < NCH always, so any tid >= NCH falls out as a mismatch here.
    assign tid_match   = (s_axis_tid == TIDW'(exp_ch_reg));
    assign exp_ch_wrap = (exp_ch_reg == LAST_CH) ? '0 : exp_ch_reg + EW'(1);

    always_comb begin
        fwd         = 1'b0;
        tlast_in    = 1'b0;
        err_inc     = 1'b0;
        state_next  = state_reg;
        exp_ch_next = exp_ch_reg;
        if (accept) begin
            case (state_reg)
                SEEK: begin
                    // Non-zero tids are discarded silently: the fault that
                    // sent us here was already counted.
                    if (tid_is_zero) begin
                        fwd         = 1'b1;
                        tlast_in    = NCH_IS_ONE;
                        exp_ch_next = FIRST_NEXT;
                        state_next  = LOCK;
                    end
                end
                LOCK: begin
                    if (tid_match) begin
                        fwd         = 1'b1;
                        tlast_in    = (exp_ch_reg == LAST_CH);
                        exp_ch_next = exp_ch_wrap;
                    end else if (tid_is_zero) begin
                        // Early channel 0: abandon the partial frame (no tlast)
                        // and start a fresh one with this beat.
                        fwd         = 1'b1;
                        err_inc     = 1'b1;
                        tlast_in    = NCH_IS_ONE;
                        exp_ch_next = FIRST_NEXT;
                    end else begin
                        err_inc     = 1'b1;
                        exp_ch_next = '0;
                        state_next  = SEEK;
                    end
                end
                default: begin
                    state_next  = SEEK;
                    exp_ch_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        err_next = err_reg;
`ifdef STREAM_FRAMER_STATS_EN
        if (clr_stats) begin
            err_next = '0;
        end else
`endif
        if (err_inc) begin
            err_next = ERRW'(sat_inc(32'(err_reg), ERRW));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= SEEK;
            exp_ch_reg <= '0;
            err_reg    <= '0;
            synced_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            exp_ch_reg <= exp_ch_next;
            err_reg    <= err_next;
            synced_reg <= (state_next == LOCK);
        end
    end

    assign synced    = synced_reg;
    assign err_count = err_reg;

    // Output register over {tdata, tid, tlast}; dropped beats are consumed
    // under the same ready rule, they just never load.
    logic [DW+TIDW:0] out_data;

    axis_out_reg #(
        .W(DW + TIDW + 1)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (accept && fwd),
        .s_data  ({s_axis_tdata, s_axis_tid, tlast_in}),
        .s_ready (s_axis_tready),
        .m_data  (out_data),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

    assign m_axis_tdata = out_data[DW+TIDW:TIDW+1];
    assign m_axis_tid   = out_data[TIDW:1];
    assign m_axis_tlast = out_data[0];

`ifdef STREAM_FRAMER_STATS_EN
    logic [31:0] frame_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count_reg <= '0;
        end else if (clr_stats) begin
            frame_count_reg <= '0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            frame_count_reg <= frame_count_reg + 32'd1;
        end
    end

    assign frame_count = frame_count_reg;
`endif

endmodule

// File: tb/tb_stream_framer.sv
module tb_stream_framer;

    localparam int DW   = 24;
    localparam int TIDW = 8;
    localparam int NCH  = 4;
    localparam int ERRW = 16;
    localparam int ERR_MAX = (1 << ERRW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [DW-1:0]   s_axis_tdata = '0;
    logic [TIDW-1:0] s_axis_tid = '0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic [TIDW-1:0] m_axis_tid;
    logic            m_axis_tlast;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b1;
    logic            synced;
    logic [ERRW-1:0] err_count;

    stream_framer #(
        .DW(DW), .TIDW(TIDW), .NCH(NCH), .ERRW(ERRW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tid    (s_axis_tid),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .synced        (synced),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [TIDW-1:0] tid;
        logic            last;
    } beat_t;

    beat_t exp_q[$];
    beat_t got_q[$];

    // ---------------- reference model ----------------
    // A frame is the channel sequence 0,1,..,NCH-1. 'mdl_locked' says whether
    // the stream is currently aligned; 'mdl_pos' is the frame position the
    // next sample must occupy.
    bit mdl_locked;
    int mdl_pos;
    int mdl_err;

    function automatic void model_reset();
        mdl_locked = 0;
        mdl_pos    = 0;
        mdl_err    = 0;
        exp_q.delete();
        got_q.delete();
    endfunction

    function automatic void model_emit(input int tid, input logic [DW-1:0] data);
        beat_t b;
        b.data = data;
        b.tid  = TIDW'(tid);
        b.last = (tid == NCH - 1);
        exp_q.push_back(b);
    endfunction

    function automatic void model_beat(input int tid, input logic [DW-1:0] data);
        if (!mdl_locked) begin
            if (tid == 0) begin
                model_emit(tid, data);
                mdl_locked = 1;
                mdl_pos    = 1 % NCH;
            end
        end else if (tid == mdl_pos) begin
            model_emit(tid, data);
            mdl_pos = (mdl_pos + 1) % NCH;
        end else begin
            mdl_err = (mdl_err < ERR_MAX) ? mdl_err + 1 : ERR_MAX;
            if (tid == 0) begin
                model_emit(tid, data);
                mdl_pos = 1 % NCH;
            end else begin
                mdl_locked = 0;
            end
        end
    endfunction

    // ---------------- downstream ready driver ----------------
    bit ready_auto = 1;
    int ready_pct  = 100;

    always @(posedge clk) begin
        #1;
        if (ready_auto) m_axis_tready = ($urandom_range(99) < ready_pct);
    end

    // ---------------- output monitor (samples on the falling edge) ----------------
    beat_t held;
    bit    stalled = 0;

    always @(negedge clk) begin
        beat_t cur;
        cur.data = m_axis_tdata;
        cur.tid  = m_axis_tid;
        cur.last = m_axis_tlast;
        if (rst) begin
            stalled = 0;
        end else begin
            if (stalled) begin
                checks++;
                if (!m_axis_tvalid || cur !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b beat=%h, required valid=1 beat=%h",
                             m_axis_tvalid, cur, held);
                end
            end
            if (m_axis_tvalid && m_axis_tready) got_q.push_back(cur);
            stalled = m_axis_tvalid && !m_axis_tready;
            held    = cur;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish within 2 ms");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_beat(input int tid, input logic [DW-1:0] data);
        bit acc;
        int n;
        acc = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = data;
        s_axis_tid    = TIDW'(tid);
        for (n = 0; n < 500 && !acc; n++) begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout: tid %0d not accepted after %0d cycles, required acceptance", tid, n);
        end else begin
            model_beat(tid, data);
            checks++;
            if (synced !== mdl_locked) begin
                errors++;
                $display("FAIL synced_after_beat: tid %0d got synced=%0b, required %0b", tid, synced, mdl_locked);
            end
            checks++;
            if (err_count !== ERRW'(mdl_err)) begin
                errors++;
                $display("FAIL err_after_beat: tid %0d got err_count=%0d, required %0d", tid, err_count, mdl_err);
            end
        end
    endtask

    task automatic idle();
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string name);
        int n;
        s_axis_tvalid = 1'b0;
        for (n = 0; n < 2000 && got_q.size() < exp_q.size(); n++) begin
            @(posedge clk);
            #1;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d output beats, required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            $display("%s beat %0d: data=%h tid=%0d last=%0b", name, i, got_q[i].data, got_q[i].tid, got_q[i].last);
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_beat%0d: got data=%h tid=%0d last=%0b, required data=%h tid=%0d last=%0b",
                         name, i, got_q[i].data, got_q[i].tid, got_q[i].last,
                         exp_q[i].data, exp_q[i].tid, exp_q[i].last);
            end
        end
        checks++;
        if (err_count !== ERRW'(mdl_err)) begin
            errors++;
            $display("FAIL %s_err: got err_count=%0d, required %0d", name, err_count, mdl_err);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic send_list(input int tids[]);
        foreach (tids[i]) send_beat(tids[i], DW'($urandom));
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b, required 0", m_axis_tvalid); end
        checks++;
        if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_data: got %h, required 0", m_axis_tdata); end
        checks++;
        if (m_axis_tid !== '0) begin errors++; $display("FAIL reset_tid: got %0d, required 0", m_axis_tid); end
        checks++;
        if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %0b, required 0", m_axis_tlast); end
        checks++;
        if (synced !== 1'b0) begin errors++; $display("FAIL reset_synced: got %0b, required 0", synced); end
        checks++;
        if (err_count !== '0) begin errors++; $display("FAIL reset_err: got %0d, required 0", err_count); end
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_in_order();
        ready_pct = 100;
        send_list('{0, 1, 2, 3, 0, 1, 2, 3});
        check_outputs("in_order");
    endtask

    task automatic test_resync_start();
        do_reset();
        send_list('{2, 3, 0, 1, 2, 3});
        check_outputs("resync_start");
    endtask

    task automatic test_drop();
        send_list('{0, 1, 3, 0, 1, 2, 3});
        check_outputs("drop");
    endtask

    task automatic test_restart();
        do_reset();
        send_list('{0, 1, 0, 1, 2, 3});
        check_outputs("restart");
    endtask

    task automatic test_random();
        int gen_next;
        int tid;
        gen_next = 0;
        ready_pct = 30;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(99) < 85) tid = gen_next;
            else tid = $urandom_range(NCH + 1);
            gen_next = (tid + 1) % NCH;
            send_beat(tid, DW'($urandom));
            if ($urandom_range(99) < 15) idle();
        end
        check_outputs("random");
        ready_pct = 100;
    endtask

    task automatic test_reset_mid();
        ready_auto = 0;
        m_axis_tready = 1'b0;
        send_beat(0, DW'($urandom));
        s_axis_tvalid = 1'b0;
        checks++;
        if (m_axis_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL mid_preload_valid: got %0b, required 1", m_axis_tvalid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %0b, required 0", m_axis_tvalid); end
        checks++;
        if (synced !== 1'b0) begin errors++; $display("FAIL mid_reset_synced: got %0b, required 0", synced); end
        checks++;
        if (err_count !== '0) begin errors++; $display("FAIL mid_reset_err: got %0d, required 0", err_count); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        ready_auto = 1;
        ready_pct  = 100;
        m_axis_tready = 1'b1;
        @(posedge clk);
        #1;
        send_list('{0, 1, 2, 3});
        check_outputs("after_reset");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_in_order();
        test_resync_start();
        test_drop();
        test_restart();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
